spi_xfer_arbiter: RTL and testbench
===================================

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the SPI master.
REQ-002 Parameter DW, default 8, transfer data width in bits.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-005 PRESET  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester transfer request, level.
REQ-007 req_txd  in  NREQ*DW  per-requester transmit word; slice i belongs to requester i.
REQ-008 gnt  out  NREQ  one-hot grant, held from launch through the done cycle.
REQ-009 done  out  NREQ  one-cycle completion strobe to the granted requester.
REQ-010 err  out  1  one-cycle strobe, coincident with done, on timeout or abort.
REQ-011 rx_data  out  DW  received word, valid in the done cycle and held until the next done.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.
REQ-013 mstr  in  1  master-mode enable; transfers start only when high.
REQ-014 spiswai  in  1  SPI wait/stop; transfers start only when low.
REQ-015 gap_cycles  in  8  idle cycles enforced between transfers.
REQ-016 timeout  in  16  completion timeout in cycles; 0 disables the timeout.
REQ-017 send_data  out  1  one-cycle start pulse to the SPI engine.
REQ-018 tx_data  out  DW  word for the engine, stable from the launch cycle until done.
REQ-019 ss_sel  out  NREQ  one-hot slave routing, equal to gnt; all-zero when idle.
REQ-020 receive_data  in  1  engine completion pulse.
REQ-021 rx_in  in  DW  engine receive word, sampled when receive_data is high.

Function
REQ-022 FSM states: IDLE, LAUNCH, WAIT, GAP.
REQ-023 IDLE: if any req is high and mstr=1 and spiswai=0, the arbiter shall pick a winner, register gnt and ss_sel, latch req_txd slice into tx_data, and enter LAUNCH next cycle.
REQ-024 Arbitration is round-robin: search starts at the index after the last granted requester and wraps modulo NREQ; after reset the search starts at index 0.
REQ-025 LAUNCH: send_data=1 for exactly one cycle; clear the timeout counter; enter WAIT.
REQ-026 WAIT: on receive_data=1, capture rx_in into rx_data, pulse done[g], and enter GAP.
REQ-027 WAIT: the counter increments each cycle; if timeout!=0 and the counter equals timeout-1 without receive_data, pulse done[g] and err, set rx_data=0, and enter GAP.
REQ-028 WAIT: if mstr falls or spiswai rises, abort the transfer exactly as for a timeout; abort has priority over a simultaneous receive_data.
REQ-029 receive_data in the same cycle as the timeout expiry shall count as success, with no err.
REQ-030 gnt and ss_sel shall clear in the cycle after done.
REQ-031 GAP: count gap_cycles idle cycles, then enter IDLE; with gap_cycles=0, go directly to IDLE the next cycle.
REQ-032 Deasserting req after grant has no effect; the transfer completes.
REQ-033 receive_data outside WAIT shall be ignored.
REQ-034 The 16-bit counter shall never wrap; it saturates.

Reset
REQ-035 PRESET: FSM=IDLE; gnt, done, err, send_data, ss_sel, busy = 0; tx_data and rx_data = 0; round-robin pointer set so index 0 has highest priority; counters = 0.
REQ-036 Reset mid-transfer shall drop all outputs immediately, with no done or err pulse.

Structure
REQ-037 Shared package spi_arb_pkg shall hold the FSM state enum and the NREQ and DW defaults.
REQ-038 Sub-module rr_arbiter (NREQ req, last-grant pointer -> one-hot grant) shall be instantiated once.

Verification
REQ-039 Single requester: req=4'b0001, txd=8'hA5, receive_data 10 cycles after send_data with rx_in=8'h3C -> one send_data pulse, done[0] with rx_data=8'h3C, err=0.
REQ-040 Fairness: req=4'b1111 held, gap_cycles=2 -> grant order 0,1,2,3,0, with ≥2 idle cycles between done and the next send_data.
REQ-041 Timeout: timeout=16, no receive_data -> done and err 16 cycles after the LAUNCH cycle, rx_data=0.
REQ-042 Abort: spiswai raised in WAIT together with receive_data -> err=1 and done the same cycle; gated start: with mstr=0 and req=4'b0010, no send_data for 50 cycles.
REQ-043 Boundary: receive_data on the exact timeout cycle -> err=0; gap_cycles=0 and req held -> next send_data 2 cycles after done.
REQ-044 PRESET asserted mid-WAIT -> all outputs 0 the same cycle; after release, req=4'b1001 grants index 0 first.

Source files
------------

// File: rtl/spi_xfer_arbiter_pkg.sv
// spi_arb_pkg: shared FSM state type and default sizes for the SPI transfer arbiter
package spi_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} arb_state_e;
endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester, configuration and SPI-engine signals of the arbiter
interface spi_xfer_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW = DW_DEF
);
  logic [NREQ-1:0] req, gnt, done, ss_sel;
  logic [NREQ*DW-1:0] req_txd;
  logic [DW-1:0] rx_data, tx_data, rx_in;
  logic err, busy, mstr, spiswai, send_data, receive_data;
  logic [7:0] gap_cycles;
  logic [15:0] timeout;
  modport slave (
    input req, req_txd, mstr, spiswai, gap_cycles, timeout, receive_data, rx_in,
    output gnt, done, err, rx_data, busy, send_data, tx_data, ss_sel
  );
  modport master (
    output req, req_txd, mstr, spiswai, gap_cycles, timeout, receive_data, rx_in,
    input gnt, done, err, rx_data, busy, send_data, tx_data, ss_sel
  );
endinterface

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching from the index after the last grant
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt
);
  logic [IW-1:0] idx;
  logic hit;
  // first requester found walking upward from last+1, wrapping modulo NREQ
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!hit && req[idx]) begin
        gnt[idx] = 1'b1;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI master engine among NREQ requesters
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW = DW_DEF
) (
  input logic PCLK,
  input logic PRESET,
  spi_xfer_arbiter_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  arb_state_e state;
  logic [NREQ-1:0] win, gnt, done;
  logic [IW-1:0] last, win_idx;
  logic [DW-1:0] tx_data, rx_data;
  logic err, send_data, busy;
  logic [15:0] cnt;
  logic [7:0] gcnt;
  logic start, abort, tmo, fin, fail;

  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req), .last(last), .gnt(win));

  // binary index of the winner, used for the pointer update and the data slice
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) win_idx = win[i] ? IW'(i) : win_idx;
  end

  assign start = |bus.req && bus.mstr && !bus.spiswai;
  assign abort = !bus.mstr || bus.spiswai;
  assign tmo = bus.timeout != 16'd0 && cnt >= bus.timeout - 16'd1;
  assign fin = abort || bus.receive_data || tmo;
  assign fail = abort || !bus.receive_data;

  // transfer sequencer; cnt holds cycles elapsed since the launch cycle so the
  // timeout strobe lands exactly timeout cycles after send_data
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      last <= IW'(NREQ - 1);
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      send_data <= 1'b0;
      busy <= 1'b0;
      tx_data <= '0;
      rx_data <= '0;
      cnt <= '0;
      gcnt <= '0;
    end else begin
      done <= '0;
      err <= 1'b0;
      send_data <= 1'b0;
      case (state)
        IDLE: if (start) begin
          gnt <= win;
          last <= win_idx;
          tx_data <= bus.req_txd[win_idx*DW +: DW];
          cnt <= '0;
          send_data <= 1'b1;
          busy <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          cnt <= cnt + 16'd1;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= &cnt ? cnt : cnt + 16'd1;
          if (fin) begin
            done <= gnt;
            err <= fail;
            rx_data <= fail ? '0 : bus.rx_in;
            gcnt <= '0;
            state <= GAP;
          end
        end
        default: begin
          gnt <= '0;
          gcnt <= gcnt + 8'd1;
          if (gcnt >= bus.gap_cycles) begin
            busy <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.gnt = gnt;
  assign bus.ss_sel = gnt;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.rx_data = rx_data;
  assign bus.tx_data = tx_data;
  assign bus.send_data = send_data;
  assign bus.busy = busy;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed and randomized checks against a timeline model of the arbiter
module tb_spi_xfer_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  logic PCLK = 1'b0;
  logic PRESET;
  int n_cmp = 0, n_bad = 0, n_send = 0;
  int cyc = 0, t_launch = -10, t_done = -10, ready_t = 0, owner = 0, ptr = NREQ - 1;
  bit in_xfer = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] exp_txd = '0, exp_rx = '0;
  logic [NREQ-1:0] oh;
  int ts, td, ts2, s0, cd;

  always #5 PCLK = ~PCLK;

  spi_xfer_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  spi_xfer_arbiter #(.NREQ(NREQ), .DW(DW)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a transfer is a launch time, a done time and the earliest
  // cycle the arbiter may grant again; outputs are derived from those stamps.
  task automatic model_step();
    int k;
    bit ab;
    if (PRESET) begin
      cyc = 0; in_xfer = 0; exp_err = 0; t_launch = -10; t_done = -10;
      ready_t = 0; owner = 0; ptr = NREQ - 1; exp_txd = '0; exp_rx = '0;
      return;
    end
    cyc++;
    if (in_xfer && cyc - 1 > t_launch) begin
      k = cyc - 1 - t_launch;
      ab = !bus.mstr || bus.spiswai;
      if (ab || bus.receive_data || (bus.timeout != 0 && k >= int'(bus.timeout) - 1)) begin
        in_xfer = 0;
        t_done = cyc;
        exp_err = ab || !bus.receive_data;
        exp_rx = exp_err ? '0 : bus.rx_in;
        ready_t = cyc + int'(bus.gap_cycles) + 1;
      end
    end else if (!in_xfer && cyc - 1 >= ready_t && |bus.req && bus.mstr && !bus.spiswai) begin
      for (int j = 1; j <= NREQ; j++)
        if (bus.req[(ptr + j) % NREQ]) begin
          owner = (ptr + j) % NREQ;
          break;
        end
      ptr = owner;
      in_xfer = 1;
      t_launch = cyc;
      exp_txd = bus.req_txd[owner*DW +: DW];
    end
  endtask

  initial forever begin
    @(posedge PCLK or posedge PRESET);
    model_step();
  end

  initial forever begin
    @(negedge PCLK);
    if (PRESET === 1'b0) begin
      oh = (in_xfer || cyc == t_done) ? NREQ'(1) << owner : '0;
      if (bus.send_data) n_send++;
      chk("gnt", 32'(bus.gnt), 32'(oh));
      chk("ss_sel", 32'(bus.ss_sel), 32'(oh));
      chk("done", 32'(bus.done), cyc == t_done ? 32'(oh) : 32'd0);
      chk("err", 32'(bus.err), 32'(cyc == t_done && exp_err));
      chk("send_data", 32'(bus.send_data), 32'(cyc == t_launch));
      chk("busy", 32'(bus.busy), 32'(in_xfer || cyc < ready_t));
      chk("tx_data", 32'(bus.tx_data), 32'(exp_txd));
      chk("rx_data", 32'(bus.rx_data), 32'(exp_rx));
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_sig(input bit want_done, input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge PCLK);
      if (want_done ? |bus.done : bus.send_data) begin
        t = cyc;
        break;
      end
    end
    n_cmp++;
    if (t < 0) begin
      n_bad++;
      $display("FAIL wait_%s: no event within %0d cycles", want_done ? "done" : "send", lim);
    end
  endtask

  task automatic pulse_rx(input int c, input logic [DW-1:0] d);
    goto(c);
    bus.receive_data = 1'b1;
    bus.rx_in = d;
    goto(c + 1);
    bus.receive_data = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    bus.req = '0;
    bus.receive_data = 1'b0;
    bus.spiswai = 1'b0;
    bus.mstr = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  function automatic logic [15:0] pick_tmo();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 16'd0 : r == 1 ? 16'd5 : r == 2 ? 16'd12 : 16'd20;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1;
    bus.req = '0;
    bus.req_txd = '0;
    bus.mstr = 1'b1;
    bus.spiswai = 1'b0;
    bus.gap_cycles = 8'd0;
    bus.timeout = 16'd0;
    bus.receive_data = 1'b0;
    bus.rx_in = '0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_send", 32'(bus.send_data), 0);
    chk("rst_rx", 32'(bus.rx_data), 0);
    PRESET = 1'b0;

    bus.req = 4'b0001;
    bus.req_txd = 32'h000000A5;
    s0 = n_send;
    wait_sig(0, 10, ts);
    chk("single_txd", 32'(bus.tx_data), 32'hA5);
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    pulse_rx(ts + 10, 8'h3C);
    bus.req = '0;
    @(negedge PCLK);
    chk("single_done", 32'(bus.done), 32'h1);
    chk("single_rx", 32'(bus.rx_data), 32'h3C);
    chk("single_err", 32'(bus.err), 0);
    goto(cyc + 5);
    chk("single_sends", 32'(n_send - s0), 1);

    do_reset();
    bus.gap_cycles = 8'd2;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_sig(0, 40, ts);
      chk($sformatf("rr_order%0d", i), 32'(bus.gnt), 32'd1 << (i % 4));
      if (i > 0) chk("rr_gap", 32'(ts - td), 32'd4);
      pulse_rx(ts + 3, DW'(i));
      wait_sig(1, 40, td);
    end
    bus.req = '0;

    do_reset();
    bus.gap_cycles = 8'd0;
    bus.timeout = 16'd16;
    bus.req = 4'b0100;
    wait_sig(0, 10, ts);
    bus.req = '0;
    wait_sig(1, 40, td);
    chk("tmo_latency", 32'(td - ts), 32'd16);
    chk("tmo_err", 32'(bus.err), 1);
    chk("tmo_done", 32'(bus.done), 32'h4);
    chk("tmo_rx", 32'(bus.rx_data), 0);

    goto(cyc + 2);
    bus.timeout = 16'd0;
    bus.req = 4'b0001;
    wait_sig(0, 10, ts);
    bus.req = '0;
    goto(ts + 3);
    bus.spiswai = 1'b1;
    bus.receive_data = 1'b1;
    bus.rx_in = 8'h77;
    goto(ts + 4);
    bus.spiswai = 1'b0;
    bus.receive_data = 1'b0;
    @(negedge PCLK);
    chk("abort_done", 32'(bus.done), 32'h1);
    chk("abort_err", 32'(bus.err), 1);
    chk("abort_rx", 32'(bus.rx_data), 0);

    goto(cyc + 2);
    bus.mstr = 1'b0;
    bus.req = 4'b0010;
    s0 = n_send;
    repeat (50) @(negedge PCLK);
    chk("gated_sends", 32'(n_send - s0), 0);
    chk("gated_busy", 32'(bus.busy), 0);
    bus.req = '0;
    bus.mstr = 1'b1;

    goto(cyc + 2);
    bus.timeout = 16'd8;
    bus.req = 4'b1000;
    wait_sig(0, 10, ts);
    bus.req = '0;
    pulse_rx(ts + 7, 8'h5A);
    @(negedge PCLK);
    chk("edge_done", 32'(bus.done), 32'h8);
    chk("edge_err", 32'(bus.err), 0);
    chk("edge_rx", 32'(bus.rx_data), 32'h5A);

    goto(cyc + 2);
    bus.timeout = 16'd0;
    bus.req = 4'b0001;
    wait_sig(0, 10, ts);
    pulse_rx(ts + 2, 8'h11);
    wait_sig(1, 10, td);
    wait_sig(0, 10, ts2);
    bus.req = '0;
    chk("gap0_restart", 32'(ts2 - td), 32'd2);
    pulse_rx(ts2 + 2, 8'h22);
    wait_sig(1, 10, td);

    goto(cyc + 2);
    bus.req = 4'b0100;
    wait_sig(0, 10, ts);
    bus.req = '0;
    goto(ts + 3);
    PRESET = 1'b1;
    #1;
    chk("rstmid_gnt", 32'(bus.gnt), 0);
    chk("rstmid_ss", 32'(bus.ss_sel), 0);
    chk("rstmid_done", 32'(bus.done), 0);
    chk("rstmid_err", 32'(bus.err), 0);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_txd", 32'(bus.tx_data), 0);
    @(posedge PCLK);
    #1;
    bus.req = 4'b1001;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    wait_sig(0, 10, ts);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    pulse_rx(ts + 2, 8'h33);
    wait_sig(1, 10, td);

    do_reset();
    cd = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge PCLK);
      #1;
      if (!bus.busy && $urandom_range(0, 7) == 0) begin
        bus.timeout = pick_tmo();
        bus.gap_cycles = 8'($urandom_range(0, 3));
      end
      if (bus.send_data) cd = $urandom_range(1, 25);
      bus.receive_data = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.receive_data = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) bus.receive_data = 1'b1;
      bus.rx_in = DW'($urandom);
      bus.req_txd = (NREQ*DW)'($urandom);
      bus.req = $urandom_range(0, 3) == 0 ? '0 : NREQ'($urandom);
      bus.mstr = $urandom_range(0, 40) != 0;
      bus.spiswai = $urandom_range(0, 50) == 0;
    end
    bus.req = '0;
    goto(cyc + 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
